// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO in front of the UART transmit stage. Producers may write at any
//   rate. Bytes are held in order and launched one at a time to the
//   transmitter with a single-cycle tx_enable pulse whenever it reports ready.
//
// Ports
//   clk             system clock, all logic on posedge
//   reset           synchronous, active-low reset
//   wr_en, wr_data  write strobe and byte to enqueue
//   clear_overflow  clears the sticky overflow flag
//   full, empty     no free entries / no stored entries
//   count           stored entries, 0..DEPTH
//   overflow        sticky: a write was dropped while full
//   tx_ready        transmitter idle and able to accept a byte
//   tx_enable       one-cycle launch pulse to the transmitter
//   tx_data         byte presented with tx_enable, held until the next launch
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   clear_overflow,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   tx_ready,
  output logic                   tx_enable,
  output logic [7:0]             tx_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_READY
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            wr_accept;
  logic            pop;

  // Pointers carry one extra bit, so their difference spans 0..DEPTH.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);

  // A pop in the same cycle never frees space for this cycle's write.
  assign wr_accept = wr_en && !full;
  assign pop       = (state_q == IDLE) && tx_ready && !empty;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (pop)       state_d = LAUNCH;
      LAUNCH:                    state_d = WAIT_BUSY;
      // Wait for the transmitter to take the byte before trusting ready again.
      WAIT_BUSY:  if (!tx_ready) state_d = WAIT_READY;
      WAIT_READY: if (tx_ready)  state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // NOTE: storage has no reset; its contents are only ever read behind the
  // pointers, and leaving it out of reset keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      tx_enable <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      state_q   <= state_d;
      // Only set on the IDLE->LAUNCH edge, so it is high for LAUNCH only.
      tx_enable <= pop;

      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;

      if (pop) begin
        tx_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end

      // A dropped write in the same cycle as a clear keeps the flag set.
      if (wr_en && full)       overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule
